alu_seq: RTL and testbench

Parametrised, registered successor to the team's 1-bit opcode ALU. It takes WIDTH-bit operands and a 3-bit opcode over a valid/ready handshake. Results and status flags come out on a registered valid/ready output port. Single-cycle ops complete in one clock. MUL runs as an iterative shift-add over WIDTH clocks. The block sits between an operand-fetch stage and a writeback/flag register stage in the datapath.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_mul.sv | 48 ++++
 rtl/alu_seq.sv | 154 +++++++++++++++
 tb/tb_alu_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq shared definitions: opcodes, FSM encoding, flag bundle.
// Imported by the top and the multiplier.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic n;
  } flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per clock.
// done/product show the final step combinationally so the top can load it.
import alu_seq_pkg::*;

module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign acc_nxt = mplier[0] ? acc + mcand : acc;
  assign done    = (cnt == CW'(1));
  assign product = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready ports and an optional
// iterative multiplier; single-cycle ops sustain 1 op/clk.
import alu_seq_pkg::*;

module alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             busy
);

  localparam int W = WIDTH;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic [2*W-1:0]   product;
  logic [W:0]       sum;
  logic [W:0]       diff;
  logic [W-1:0]     alu_res;
  logic             alu_c;
  logic             alu_v;
  flags_t           alu_flg;
  flags_t           mul_flg;
  flags_t           flg;

  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MUL) && MUL_EN;
  assign mul_start = accept && is_mul;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (1'b1)
      (op == OP_AND): alu_res = a & b;
      (op == OP_OR):  alu_res = a | b;
      (op == OP_XOR): alu_res = a ^ b;
      (op == OP_ADD): begin
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      (op == OP_SUB): begin
        alu_res = diff[W-1:0];
        alu_c   = diff[W];
        alu_v   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      (op == OP_SHL):
        alu_res = (b >= W'(WIDTH)) ? '0 : (a << b);
      (op == OP_SHR):
        alu_res = (b >= W'(WIDTH)) ? '0 : (a >> b);
      // Without a multiplier, MUL collapses to a zero result.
      (op == OP_MUL): alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    alu_flg.z = (alu_res == '0);
    alu_flg.c = alu_c;
    alu_flg.v = alu_v;
    alu_flg.n = alu_res[W-1];
  end

  always_comb begin
    mul_flg.z = (product[W-1:0] == '0);
    mul_flg.c = |product[2*W-1:W];
    mul_flg.v = 1'b0;
    mul_flg.n = product[W-1];
  end

  if (MUL_EN) begin : g_mul
    alu_seq_mul #(
      .WIDTH(W)
    ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (product)
    );
  end else begin : g_nomul
    assign mul_done = 1'b0;
    assign product  = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (mul_start) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_MUL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flg       <= '0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      flg       <= alu_flg;
    end else if (mul_start) begin
      out_valid <= 1'b0;
    end else if (busy && mul_done) begin
      out_valid <= 1'b1;
      result    <= product[W-1:0];
      flg       <= mul_flg;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign flag_z = flg.z;
  assign flag_c = flg.c;
  assign flag_v = flg.v;
  assign flag_n = flg.n;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8, MUL_EN=1).
// Expected results are queued at accept, compared at output transfer.
import alu_seq_pkg::*;

module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic       flag_z, flag_c, flag_v, flag_n;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [11:0] sb[$];

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_n    (flag_n),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic [2:0] o,
                                        input logic [7:0] x,
                                        input logic [7:0] y);
    int unsigned u;
    int sx, sy, s;
    logic c, v;
    logic [7:0] r;
    u = 0; c = 0; v = 0; s = 0;
    sx = (x > 127) ? int'(x) - 256 : int'(x);
    sy = (y > 127) ? int'(y) - 256 : int'(y);
    case (o)
      3'b000: u = int'(x & y);
      3'b001: u = int'(x | y);
      3'b100: u = int'(x ^ y);
      3'b010: begin
        u = int'(x) + int'(y);
        c = (u > 255);
        s = sx + sy;
        v = (s > 127) || (s < -128);
      end
      3'b011: begin
        u = (int'(x) - int'(y)) & 255;
        c = (x < y);
        s = sx - sy;
        v = (s > 127) || (s < -128);
      end
      3'b101: u = (y >= 8) ? 0 : ((int'(x) << y) & 255);
      3'b110: u = (y >= 8) ? 0 : (int'(x) >> y);
      default: begin
        u = int'(x) * int'(y);
        c = (u > 255);
      end
    endcase
    r = u[7:0];
    return {r, (r == 8'h00), c, v, r[7]};
  endfunction

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [2:0] o, input logic [7:0] x,
                      input logic [7:0] y);
    int n;
    n = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    sb.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_out", 32'(sb.size()), 32'd1);
      end else begin
        chk("out", {20'd0, result, flag_z, flag_c, flag_v, flag_n},
            {20'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    int n;
    logic [11:0] held;
    logic [2:0]  ro;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {25'd0, out_valid, busy, result[3:0], flag_z, flag_c},
        32'd0);
    chk("rst_res", {20'd0, result, flag_z, flag_c, flag_v, flag_n}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);

    send(OP_ADD, 8'hff, 8'h01);
    chk("add_lat", {31'd0, out_valid}, 32'd1);
    send(OP_ADD, 8'h7f, 8'h01);
    send(OP_SUB, 8'h80, 8'h01);
    send(OP_SUB, 8'h00, 8'h01);
    send(OP_SHL, 8'h01, 8'h07);
    send(OP_SHL, 8'h01, 8'h09);
    send(OP_SHR, 8'h80, 8'h08);
    send(OP_SHR, 8'h80, 8'h03);
    send(OP_XOR, 8'ha5, 8'h5a);
    send(OP_OR,  8'h00, 8'h00);

    send(OP_MUL, 8'h0f, 8'h11);
    chk("mul_busy", {30'd0, busy, out_valid}, 32'd2);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_lat", 32'(n), 32'd8);
    chk("mul_done_busy", {31'd0, busy}, 32'd0);
    send(OP_MUL, 8'h10, 8'h10);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul2_lat", 32'(n), 32'd8);

    send(OP_MUL, 8'hff, 8'hff);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mulrst_out", {22'd0, out_valid, busy, result}, 32'd0);
    chk("mulrst_flg", {28'd0, flag_z, flag_c, flag_v, flag_n}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mulrst_after", {29'd0, out_valid, busy, in_ready}, 32'd1);

    out_ready = 1'b0;
    send(OP_AND, 8'hf0, 8'h3c);
    held = model(OP_AND, 8'hf0, 8'h3c);
    op = OP_OR; a = 8'h11; b = 8'h22; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_rdy", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", {19'd0, out_valid, result, flag_z, flag_c, flag_v,
          flag_n}, {19'd0, 1'b1, held});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(OP_AND, 8'(8'h0f << i), 8'h3f);
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    end

    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 7));
      send(ro, 8'($urandom), 8'($urandom_range(0, 10)));
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
